// File: rtl/serial_uart_rx_deserializer_if.sv
// Receive-word handshake bundle between the UART RX deserializer and its consumer.
// The deserializer drives through master; the consumer acknowledges through slave.
interface serial_uart_rx_deserializer_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] RX_DATA;
    logic                 RX_DATA_VALID;
    logic                 RX_DATA_ACK;
    logic                 RX_FRAME_ERR;
    logic                 RX_OVERRUN;
    logic                 RX_BUSY;

    modport master (
        output RX_DATA, RX_DATA_VALID, RX_FRAME_ERR, RX_OVERRUN, RX_BUSY,
        input  RX_DATA_ACK
    );

    modport slave (
        input  RX_DATA, RX_DATA_VALID, RX_FRAME_ERR, RX_OVERRUN, RX_BUSY,
        output RX_DATA_ACK
    );
endinterface

// File: rtl/serial_uart_rx_deserializer.sv
// UART receiver: synchronizes RX, samples at x16 ticks with a 2-of-3 mid-bit vote,
// assembles an LSB-first frame and holds the word on a valid/ack handshake.
module serial_uart_rx_deserializer #(
    parameter int DATA_BITS   = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic CLK,
    input  logic RESET,
    input  logic BAUD_SAMPLE_TICK,
    input  logic UART_RX,
    serial_uart_rx_deserializer_if.master rx_if
);
    localparam int IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_STOP, S_BREAK
    } state_t;

    state_t               state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                 rx_s;
    logic [3:0]           cnt_q, cnt_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic                 s7_q, s7_d, s8_q, s8_d;
    logic [DATA_BITS-1:0] shift_q, shift_d, data_q, data_d;
    logic                 valid_q, valid_d, ferr_q, ferr_d, ovr_q, ovr_d;
    logic                 vote, last_bit;
    logic                 busy, shift_en, deliver, frame_err, idx_clr, idx_inc;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) sync_q <= '1;
        else       sync_q <= {sync_q[SYNC_STAGES-2:0], UART_RX};
    end

    assign rx_s     = sync_q[SYNC_STAGES-1];
    // Third vote sample is the live rx_s on the cnt=9 tick itself.
    assign vote     = (s7_q & s8_q) | (s7_q & rx_s) | (s8_q & rx_s);
    assign last_bit = (idx_q == IDX_W'(DATA_BITS - 1));

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (BAUD_SAMPLE_TICK) begin
            unique case (state_q)
                S_IDLE:  if (!rx_s) state_d = S_START;
                S_START: begin
                    if (cnt_q == 4'd9 && vote) state_d = S_IDLE;
                    else if (cnt_q == 4'd15)   state_d = S_DATA;
                end
                S_DATA:  if (cnt_q == 4'd15 && last_bit) state_d = S_STOP;
                S_STOP:  if (cnt_q == 4'd9) state_d = vote ? S_IDLE : S_BREAK;
                S_BREAK: if (rx_s) state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        busy      = (state_q != S_IDLE);
        shift_en  = BAUD_SAMPLE_TICK && (state_q == S_DATA) && (cnt_q == 4'd9);
        deliver   = BAUD_SAMPLE_TICK && (state_q == S_STOP) && (cnt_q == 4'd9) && vote;
        frame_err = BAUD_SAMPLE_TICK && (state_q == S_STOP) && (cnt_q == 4'd9) && !vote;
        idx_clr   = BAUD_SAMPLE_TICK && (state_q == S_START) && (cnt_q == 4'd15);
        idx_inc   = BAUD_SAMPLE_TICK && (state_q == S_DATA) && (cnt_q == 4'd15) && !last_bit;
    end

    always_comb begin
        cnt_d   = cnt_q;
        s7_d    = s7_q;
        s8_d    = s8_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        data_d  = data_q;
        valid_d = valid_q;
        ferr_d  = frame_err;
        ovr_d   = 1'b0;
        // Holding cnt at 0 in IDLE makes the start-edge tick the cnt=0 reference.
        if (BAUD_SAMPLE_TICK) begin
            cnt_d = (state_q == S_IDLE) ? 4'd0 : cnt_q + 4'd1;
            if (cnt_q == 4'd7) s7_d = rx_s;
            if (cnt_q == 4'd8) s8_d = rx_s;
        end
        if (idx_clr)       idx_d = '0;
        else if (idx_inc)  idx_d = idx_q + IDX_W'(1);
        if (shift_en) shift_d = {vote, shift_q[DATA_BITS-1:1]};
        if (deliver) begin
            if (!valid_q || rx_if.RX_DATA_ACK) begin
                data_d  = shift_q;
                valid_d = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end else if (valid_q && rx_if.RX_DATA_ACK) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            cnt_q   <= '0;
            s7_q    <= 1'b1;
            s8_q    <= 1'b1;
            idx_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            s7_q    <= s7_d;
            s8_q    <= s8_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
            ovr_q   <= ovr_d;
        end
    end

    assign rx_if.RX_DATA       = data_q;
    assign rx_if.RX_DATA_VALID = valid_q;
    assign rx_if.RX_FRAME_ERR  = ferr_q;
    assign rx_if.RX_OVERRUN    = ovr_q;
    assign rx_if.RX_BUSY       = busy;
endmodule

// File: tb/tb_serial_uart_rx_deserializer.sv
// Directed bench for serial_uart_rx_deserializer: tick every 4 CLK, 64 CLK per bit,
// scoreboard of expected words checked by a delivery monitor.
module tb_serial_uart_rx_deserializer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic tick = 1'b0;
    logic uart_rx = 1'b1;

    serial_uart_rx_deserializer_if #(.DATA_BITS(8)) rx_if ();

    serial_uart_rx_deserializer #(.DATA_BITS(8), .SYNC_STAGES(2)) dut (
        .CLK              (clk),
        .RESET            (rst),
        .BAUD_SAMPLE_TICK (tick),
        .UART_RX          (uart_rx),
        .rx_if            (rx_if.master)
    );

    always #5 clk = ~clk;

    int ntests = 0;
    int nfail  = 0;
    int ferr_cnt = 0;
    int ovr_cnt  = 0;
    logic [7:0] sb[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ntests++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Tick generator: one-CLK pulse every 4 CLK, driven just after the falling edge.
    int kph = 0;
    initial begin
        forever begin
            @(negedge clk);
            #1;
            tick = (kph == 0);
            kph  = (kph + 1) % 4;
        end
    end

    // Delivery monitor: a new word is valid after an edge where valid was low or ack was high.
    logic ack_seen = 1'b0, tick_seen = 1'b0, prev_valid = 1'b0, prev_busy = 1'b0;
    always @(posedge clk) begin
        ack_seen  <= rx_if.RX_DATA_ACK;
        tick_seen <= tick;
    end
    always @(negedge clk) begin
        if (!rst && rx_if.RX_DATA_VALID && (!prev_valid || ack_seen)) begin
            chk("sb_pending", 32'(sb.size() != 0), 1);
            if (sb.size() != 0) chk("sb_data", rx_if.RX_DATA, sb.pop_front());
            chk("deliver_on_tick", tick_seen, 1);
            chk("busy_before_deliver", prev_busy, 1);
            chk("busy_at_deliver", rx_if.RX_BUSY, 0);
        end
        if (rx_if.RX_FRAME_ERR) ferr_cnt <= ferr_cnt + 1;
        if (rx_if.RX_OVERRUN)   ovr_cnt  <= ovr_cnt + 1;
        prev_valid <= rx_if.RX_DATA_VALID;
        prev_busy  <= rx_if.RX_BUSY;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed timeout, required finish");
        $fatal(1, "watchdog");
    end

    task automatic hold(input logic v, input int n);
        uart_rx = v;
        repeat (n) begin @(negedge clk); #2; end
    endtask

    task automatic ack_pulse();
        rx_if.RX_DATA_ACK = 1'b1;
        @(negedge clk); #2;
        rx_if.RX_DATA_ACK = 1'b0;
        chk("ack_clears_valid", rx_if.RX_DATA_VALID, 0);
    endtask

    // kind: 0 none, 1 good delivery, 2 frame error, 3 overrun (keep = held word).
    // Line falls with a tick at the next edge, so the STOP cnt=9 tick lands on CLK 620.
    task automatic send_frame(input logic [7:0] d, input logic stop_v, input int ack_cyc,
                              input int abort_cyc, input int kind, input logic [7:0] keep);
        logic [9:0] bits;
        int w;
        bits = {stop_v, d, 1'b0};
        w = 0;
        while (tick !== 1'b1 && w < 8) begin @(negedge clk); #2; w++; end
        chk("tick_align", tick, 1);
        for (int m = 0; m < 640; m++) begin
            if (m == abort_cyc) return;
            uart_rx = bits[m/64];
            rx_if.RX_DATA_ACK = (m == ack_cyc);
            if (kind == 1 && m == 620) chk("busy_in_stop", rx_if.RX_BUSY, 1);
            if (kind == 1 && m == 621) begin
                chk("rx_data", rx_if.RX_DATA, d);
                chk("rx_valid", rx_if.RX_DATA_VALID, 1);
                chk("busy_fall", rx_if.RX_BUSY, 0);
                chk("no_ferr", rx_if.RX_FRAME_ERR, 0);
                chk("no_ovr", rx_if.RX_OVERRUN, 0);
            end
            if (kind == 2 && m == 621) begin
                chk("ferr_pulse", rx_if.RX_FRAME_ERR, 1);
                chk("ferr_no_valid", rx_if.RX_DATA_VALID, 0);
            end
            if (kind == 2 && m == 622) chk("ferr_one_cycle", rx_if.RX_FRAME_ERR, 0);
            if (kind == 3 && m == 621) begin
                chk("ovr_pulse", rx_if.RX_OVERRUN, 1);
                chk("ovr_keep_data", rx_if.RX_DATA, keep);
                chk("ovr_keep_valid", rx_if.RX_DATA_VALID, 1);
            end
            if (kind == 3 && m == 622) chk("ovr_one_cycle", rx_if.RX_OVERRUN, 0);
            @(negedge clk); #2;
        end
        rx_if.RX_DATA_ACK = 1'b0;
    endtask

    initial begin
        rx_if.RX_DATA_ACK = 1'b0;
        @(negedge clk); #2;
        chk("rst_data", rx_if.RX_DATA, 0);
        chk("rst_valid", rx_if.RX_DATA_VALID, 0);
        chk("rst_ferr", rx_if.RX_FRAME_ERR, 0);
        chk("rst_ovr", rx_if.RX_OVERRUN, 0);
        chk("rst_busy", rx_if.RX_BUSY, 0);
        rst = 1'b0;
        hold(1'b1, 40);

        // Clean frame, then acknowledge
        sb.push_back(8'hA5);
        send_frame(8'hA5, 1'b1, -1, -1, 1, 8'h00);
        ack_pulse();
        chk("data_kept_after_ack", rx_if.RX_DATA, 8'hA5);
        hold(1'b1, 40);

        // Two-tick low glitch: START entered, then rejected at the vote
        begin
            int w;
            w = 0;
            while (tick !== 1'b1 && w < 8) begin @(negedge clk); #2; w++; end
            for (int m = 0; m < 60; m++) begin
                uart_rx = (m < 8) ? 1'b0 : 1'b1;
                if (m == 10) chk("glitch_busy", rx_if.RX_BUSY, 1);
                if (m == 50) chk("glitch_idle", rx_if.RX_BUSY, 0);
                @(negedge clk); #2;
            end
            chk("glitch_no_valid", rx_if.RX_DATA_VALID, 0);
            chk("glitch_no_ferr", ferr_cnt, 0);
        end

        // Bad stop bit followed by a held break
        send_frame(8'h3C, 1'b0, -1, -1, 2, 8'h00);
        hold(1'b0, 192);
        chk("break_ferr_count", ferr_cnt, 1);
        chk("break_no_valid", rx_if.RX_DATA_VALID, 0);
        chk("break_busy", rx_if.RX_BUSY, 1);
        hold(1'b1, 64);
        chk("break_released", rx_if.RX_BUSY, 0);
        sb.push_back(8'h81);
        send_frame(8'h81, 1'b1, -1, -1, 1, 8'h00);
        ack_pulse();
        hold(1'b1, 20);

        // Overrun: second word dropped while first is unacknowledged
        sb.push_back(8'h11);
        send_frame(8'h11, 1'b1, -1, -1, 1, 8'h00);
        hold(1'b1, 20);
        send_frame(8'h22, 1'b1, -1, -1, 3, 8'h11);
        chk("ovr_data_held", rx_if.RX_DATA, 8'h11);
        chk("ovr_count", ovr_cnt, 1);
        ack_pulse();
        hold(1'b1, 20);

        // Ack in the same cycle as the next delivery: replace, no overrun
        sb.push_back(8'h55);
        send_frame(8'h55, 1'b1, -1, -1, 1, 8'h00);
        hold(1'b1, 20);
        sb.push_back(8'h66);
        send_frame(8'h66, 1'b1, 620, -1, 1, 8'h00);
        chk("ack_same_cycle_ovr", ovr_cnt, 1);
        hold(1'b1, 20);

        // Reset during the 4th data bit (valid still high with 0x66)
        send_frame(8'hF0, 1'b1, -1, 276, 0, 8'h00);
        chk("busy_midframe", rx_if.RX_BUSY, 1);
        rst = 1'b1;
        #1;
        chk("mid_rst_data", rx_if.RX_DATA, 0);
        chk("mid_rst_valid", rx_if.RX_DATA_VALID, 0);
        chk("mid_rst_ferr", rx_if.RX_FRAME_ERR, 0);
        chk("mid_rst_ovr", rx_if.RX_OVERRUN, 0);
        chk("mid_rst_busy", rx_if.RX_BUSY, 0);
        @(negedge clk); #2;
        hold(1'b1, 3);
        rst = 1'b0;
        hold(1'b1, 64);
        sb.push_back(8'h0F);
        send_frame(8'h0F, 1'b1, -1, -1, 1, 8'h00);
        ack_pulse();
        hold(1'b1, 20);

        chk("sb_drained", sb.size(), 0);
        chk("ferr_total", ferr_cnt, 1);
        chk("ovr_total", ovr_cnt, 1);
        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end
endmodule
